qspi_flash_seq: RTL



---
 rtl/qspi_pkg.sv | 69 ++++++
 rtl/qspi_flash_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_pkg.sv
// -----------------------------------------------------------------------------
// qspi_pkg
// Shared definitions for the QSPI flash controller slice:
//   - SPI-NOR opcode constants
//   - cmd_cfg field offsets and the canned cfg words used by the sequencer
//   - status register bit indices
//   - seq_err completion codes
//   - a small command record plus a helper that maps a request op to its
//     main (write-class) command
// -----------------------------------------------------------------------------
package qspi_pkg;

    // Flash opcodes
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_CE   = 8'hC7;

    // cmd_cfg field offsets
    localparam int unsigned CFG_CMD_LSB    = 0;   // [1:0]
    localparam int unsigned CFG_ADDR_LSB   = 2;   // [3:2]
    localparam int unsigned CFG_DATA_LSB   = 4;   // [5:4]
    localparam int unsigned CFG_ABYTES_LSB = 6;   // [7:6]
    localparam int unsigned CFG_MODE_EN    = 8;   // [8]
    localparam int unsigned CFG_DUMMY_LSB  = 9;   // [12:9]
    localparam int unsigned CFG_DIR        = 13;  // [13], 1 = read

    // Status register bits
    localparam int unsigned SR_WIP = 0;
    localparam int unsigned SR_WEL = 1;

    // Canned cfg words, all single-lane
    localparam logic [15:0] CFG_PLAIN = 16'h0000;
    localparam logic [15:0] CFG_READ  = 16'(1 << CFG_DIR);          // 0x2000
    localparam logic [15:0] CFG_ADDR3 = 16'(1 << CFG_ABYTES_LSB);   // 0x0040

    typedef enum logic [1:0] {
        SEQ_OK          = 2'd0,
        SEQ_ERR_WEL     = 2'd1,
        SEQ_ERR_TIMEOUT = 2'd2,
        SEQ_ERR_BADOP   = 2'd3
    } seq_err_e;

    typedef struct packed {
        logic [15:0] cfg;
        logic [7:0]  op;
        logic [31:0] len;
    } qspi_cmd_t;

    localparam qspi_cmd_t CMD_WREN = '{cfg: CFG_PLAIN, op: OP_WREN, len: 32'd0};
    localparam qspi_cmd_t CMD_RDSR = '{cfg: CFG_READ,  op: OP_RDSR, len: 32'd1};

    // Main command for a request op: 0 page program, 1 sector erase,
    // 2 chip erase. Op 3 never reaches here.
    function automatic qspi_cmd_t main_cmd(input logic [1:0] sel, input logic [31:0] pp_len);
        qspi_cmd_t c;
        case (sel)
            2'd0:    c = '{cfg: CFG_ADDR3, op: OP_PP, len: pp_len};
            2'd1:    c = '{cfg: CFG_ADDR3, op: OP_SE, len: 32'd0};
            default: c = '{cfg: CFG_PLAIN, op: OP_CE, len: 32'd0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/qspi_flash_seq.sv
// -----------------------------------------------------------------------------
// qspi_flash_seq
// Command sequencer in front of qspi_fsm. One write-class request becomes
// WREN -> RDSR (WEL check) -> main command -> RDSR polling until WIP clears.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req, req_op, req_addr, request pulse (IDLE only), op select, flash
//   req_len                address, page-program byte count
//   busy, seq_done,        sequence in flight, completion pulse, result code
//   seq_err, sr_last       and last captured status byte
//   start, cmd_cfg, cmd_op, command bundle to qspi_fsm (start pulses for one
//   cmd_addr, cmd_dummy,   cycle; cmd_* are held until the next issue)
//   cmd_len
//   done, rx_wen,          completion and RX byte stream from qspi_fsm
//   rx_data_fifo
// -----------------------------------------------------------------------------
module qspi_flash_seq
    import qspi_pkg::*;
#(
    parameter int unsigned POLL_MAX = 50000,
    parameter int unsigned POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_len,
    output logic        busy,
    output logic        seq_done,
    output logic [1:0]  seq_err,
    output logic [7:0]  sr_last,
    output logic        start,
    output logic [15:0] cmd_cfg,
    output logic [15:0] cmd_op,
    output logic [31:0] cmd_addr,
    output logic [7:0]  cmd_dummy,
    output logic [31:0] cmd_len,
    input  logic        done,
    input  logic        rx_wen,
    input  logic [7:0]  rx_data_fifo
);

    typedef enum logic [3:0] {
        IDLE, WREN, WREN_W, WEL, WEL_W, MAIN, MAIN_W, GAP, POLL, POLL_W, FIN
    } state_e;

    localparam logic [31:0] POLL_MAX_C = 32'(POLL_MAX);
    // A zero gap still spends one cycle in GAP
    localparam logic [31:0] GAP_LAST   = (POLL_GAP == 0) ? 32'd0 : 32'(POLL_GAP - 1);

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        seq_done_q, seq_done_d;
    seq_err_e    err_q, err_d;
    logic [7:0]  sr_last_q, sr_last_d;
    logic        sr_got_q, sr_got_d;
    logic        start_q, start_d;
    logic [15:0] cmd_cfg_q, cmd_cfg_d;
    logic [7:0]  cmd_op_q, cmd_op_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_len_q, cmd_len_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] len_q, len_d;
    logic [31:0] poll_cnt_q, poll_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;

    logic        issue;
    qspi_cmd_t   issue_cmd;
    logic [23:0] issue_addr;
    logic [7:0]  sr_now;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        seq_done_d = 1'b0;
        err_d      = err_q;
        sr_last_d  = sr_last_q;
        sr_got_d   = sr_got_q;
        start_d    = 1'b0;
        cmd_cfg_d  = cmd_cfg_q;
        cmd_op_d   = cmd_op_q;
        cmd_addr_d = cmd_addr_q;
        cmd_len_d  = cmd_len_q;
        op_d       = op_q;
        addr_d     = addr_q;
        len_d      = len_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        issue      = 1'b0;
        issue_cmd  = CMD_WREN;
        issue_addr = addr_q;

        // First status byte of an RDSR wins; sr_now lets a byte arriving
        // together with done drive the decision in that same cycle.
        sr_now = sr_last_q;
        if ((state_q == WEL_W || state_q == POLL_W) && rx_wen && !sr_got_q) begin
            sr_now    = rx_data_fifo;
            sr_last_d = rx_data_fifo;
            sr_got_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    busy_d     = 1'b1;
                    err_d      = SEQ_OK;
                    poll_cnt_d = '0;
                    op_d       = req_op;
                    addr_d     = req_addr;
                    len_d      = req_len;
                    if (req_op == 2'd3) begin
                        err_d   = SEQ_ERR_BADOP;
                        state_d = FIN;
                    end else begin
                        issue      = 1'b1;
                        issue_cmd  = CMD_WREN;
                        issue_addr = req_addr;
                        state_d    = WREN;
                    end
                end
            end
            WREN:   state_d = WREN_W;
            WREN_W: begin
                if (done) begin
                    issue     = 1'b1;
                    issue_cmd = CMD_RDSR;
                    state_d   = WEL;
                end
            end
            WEL: begin
                sr_got_d = 1'b0;
                state_d  = WEL_W;
            end
            WEL_W: begin
                if (done) begin
                    if (!sr_now[SR_WEL]) begin
                        err_d   = SEQ_ERR_WEL;
                        state_d = FIN;
                    end else begin
                        issue     = 1'b1;
                        issue_cmd = main_cmd(op_q, len_q);
                        state_d   = MAIN;
                    end
                end
            end
            MAIN:   state_d = MAIN_W;
            MAIN_W: begin
                if (done) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    issue      = 1'b1;
                    issue_cmd  = CMD_RDSR;
                    poll_cnt_d = poll_cnt_q + 32'd1;
                    state_d    = POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            POLL: begin
                sr_got_d = 1'b0;
                state_d  = POLL_W;
            end
            POLL_W: begin
                if (done) begin
                    if (!sr_now[SR_WIP]) begin
                        err_d   = SEQ_OK;
                        state_d = FIN;
                    end else if (poll_cnt_q == POLL_MAX_C) begin
                        err_d   = SEQ_ERR_TIMEOUT;
                        state_d = FIN;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            FIN: begin
                busy_d     = 1'b0;
                seq_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every transition into an issue state loads the bundle and raises
        // start, so both appear registered in the issue cycle itself.
        if (issue) begin
            start_d    = 1'b1;
            cmd_cfg_d  = issue_cmd.cfg;
            cmd_op_d   = issue_cmd.op;
            cmd_len_d  = issue_cmd.len;
            cmd_addr_d = {8'h00, issue_addr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= SEQ_OK;
            sr_last_q  <= '0;
            sr_got_q   <= 1'b0;
            start_q    <= 1'b0;
            cmd_cfg_q  <= '0;
            cmd_op_q   <= '0;
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
            err_q      <= err_d;
            sr_last_q  <= sr_last_d;
            sr_got_q   <= sr_got_d;
            start_q    <= start_d;
            cmd_cfg_q  <= cmd_cfg_d;
            cmd_op_q   <= cmd_op_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_len_q  <= cmd_len_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign seq_done  = seq_done_q;
    assign seq_err   = err_q;
    assign sr_last   = sr_last_q;
    assign start     = start_q;
    assign cmd_cfg   = cmd_cfg_q;
    assign cmd_op    = {8'h00, cmd_op_q};
    assign cmd_addr  = cmd_addr_q;
    assign cmd_dummy = 8'h00;
    assign cmd_len   = cmd_len_q;

endmodule
